// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store controller between a pipeline
// memory stage and a 64-bit-wide memory bus.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   -> misaligned H/UH/W/UW/D accesses complete immediately with
//                resp_err=1 and never reach the bus
//   undefined -> no alignment check, resp_err tied low, misaligned accesses
//                issue with a truncated byte mask
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_we, req_op           store/load select, size and signedness
//   req_addr, req_wdata      byte address, unshifted store data
//   resp_valid, resp_rdata   one-cycle completion pulse, extended load data
//   resp_err                 misaligned-access flag (trap build only)
//   mem_req, mem_wen         bus request and write enable
//   mem_addr, mem_wdata      doubleword-aligned address, lane-shifted data
//   mem_wmask                byte-lane write mask
//   mem_ready                bus accepts the request
//   mem_rvalid, mem_rdata    read return
//   stall                    high whenever the controller is busy

package CorePack;
    typedef logic [63:0] data_t;

    typedef enum logic [2:0] {
        MEM_NO = 3'd0,
        MEM_B  = 3'd1,
        MEM_H  = 3'd2,
        MEM_W  = 3'd3,
        MEM_D  = 3'd4,
        MEM_UB = 3'd5,
        MEM_UH = 3'd6,
        MEM_UW = 3'd7
    } mem_op_enum;
endpackage

module mem_access_ctrl
    import CorePack::*;
#(
    parameter int unsigned ADDR_W = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  CorePack::mem_op_enum   req_op,
    input  logic [ADDR_W-1:0]      req_addr,
    input  CorePack::data_t        req_wdata,
    output logic                   resp_valid,
    output CorePack::data_t        resp_rdata,
    output logic                   resp_err,
    output logic                   mem_req,
    output logic                   mem_wen,
    output logic [ADDR_W-1:0]      mem_addr,
    output CorePack::data_t        mem_wdata,
    output logic [7:0]             mem_wmask,
    input  logic                   mem_ready,
    input  logic                   mem_rvalid,
    input  CorePack::data_t        mem_rdata,
    output logic                   stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state;
    logic       lat_we;
    mem_op_enum lat_op;
    logic [2:0] lat_off;
    logic       err_q;

    function automatic logic [7:0] base_mask(input mem_op_enum op);
        logic [7:0] m;
        case (op)
            MEM_B, MEM_UB: m = 8'h01;
            MEM_H, MEM_UH: m = 8'h03;
            MEM_W, MEM_UW: m = 8'h0F;
            MEM_D:         m = 8'hFF;
            default:       m = 8'h00;
        endcase
        return m;
    endfunction

    // Bring the addressed lane down to bit 0, then size/extend it.
    function automatic data_t load_extract(input mem_op_enum op,
                                           input logic [2:0] off,
                                           input data_t raw);
        data_t s;
        data_t r;
        s = raw >> {off, 3'b000};
        case (op)
            MEM_B:   r = {{56{s[7]}},  s[7:0]};
            MEM_H:   r = {{48{s[15]}}, s[15:0]};
            MEM_W:   r = {{32{s[31]}}, s[31:0]};
            MEM_D:   r = s;
            MEM_UB:  r = {56'd0, s[7:0]};
            MEM_UH:  r = {48'd0, s[15:0]};
            MEM_UW:  r = {32'd0, s[31:0]};
            default: r = '0;
        endcase
        return r;
    endfunction

`ifdef MISALIGN_TRAP_EN
    function automatic logic misaligned(input mem_op_enum op, input logic [2:0] a);
        logic m;
        case (op)
            MEM_H, MEM_UH: m = (a[0] != 1'b0);
            MEM_W, MEM_UW: m = (a[1:0] != 2'b00);
            MEM_D:         m = (a != 3'b000);
            default:       m = 1'b0;
        endcase
        return m;
    endfunction
    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    // State is IDLE throughout reset, so readiness is masked by rst directly.
    assign req_ready = (state == IDLE) && !rst;
    assign stall     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_we     <= 1'b0;
            lat_op     <= MEM_NO;
            lat_off    <= '0;
            err_q      <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            mem_req    <= 1'b0;
            mem_wen    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_we  <= req_we;
                        lat_op  <= req_op;
                        lat_off <= req_addr[2:0];
                        if (req_op == MEM_NO) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                        end
`ifdef MISALIGN_TRAP_EN
                        else if (misaligned(req_op, req_addr[2:0])) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                            err_q      <= 1'b1;
                        end
`endif
                        else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_wen   <= req_we;
                            mem_addr  <= {req_addr[ADDR_W-1:3], 3'b000};
                            mem_wdata <= req_wdata << {req_addr[2:0], 3'b000};
                            mem_wmask <= base_mask(req_op) << req_addr[2:0];
                        end
                    end
                end

                REQ: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        if (lat_we) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                        end else if (mem_rvalid) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_rdata <= load_extract(lat_op, lat_off, mem_rdata);
                        end else begin
                            state <= WAIT;
                        end
                    end
                end

                WAIT: begin
                    if (mem_rvalid) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_extract(lat_op, lat_off, mem_rdata);
                    end
                end

                DONE: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    err_q      <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
    import CorePack::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    mem_op_enum   req_op;
    logic [63:0]  req_addr;
    data_t        req_wdata;
    logic         resp_valid;
    data_t        resp_rdata;
    logic         resp_err;
    logic         mem_req;
    logic         mem_wen;
    logic [63:0]  mem_addr;
    data_t        mem_wdata;
    logic [7:0]   mem_wmask;
    logic         mem_ready;
    logic         mem_rvalid;
    data_t        mem_rdata;
    logic         stall;

    int unsigned total = 0;
    int unsigned bad   = 0;

    mem_access_ctrl #(.ADDR_W(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         we;
        mem_op_enum   op;
        logic [63:0]  addr;
        logic [63:0]  wdata;
        logic [63:0]  rdata;
        int unsigned  rdy_dly;   // cycles mem_ready held low in REQ
        int unsigned  rv_dly;    // edges from mem_ready to mem_rvalid (0 = same edge)
        logic [63:0]  e_addr;
        logic [7:0]   e_mask;
        logic [63:0]  e_wdata;
        logic [63:0]  e_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input mem_op_enum op,
                                input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [63:0] rdata, input int unsigned rdy_dly,
                                input int unsigned rv_dly, input logic [63:0] e_addr,
                                input logic [7:0] e_mask, input logic [63:0] e_wdata,
                                input logic [63:0] e_rdata);
        vec_t v;
        v.we = we; v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.rdy_dly = rdy_dly; v.rv_dly = rv_dly; v.e_addr = e_addr;
        v.e_mask = e_mask; v.e_wdata = e_wdata; v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [63:0] held;
        req_valid = 1'b1; req_we = v.we; req_op = v.op;
        req_addr = v.addr; req_wdata = v.wdata;
        tick();
        req_valid = 1'b0;
        chk($sformatf("v%0d mem_req", idx),   64'(mem_req), 64'd1);
        chk($sformatf("v%0d mem_addr", idx),  mem_addr, v.e_addr);
        chk($sformatf("v%0d mem_wmask", idx), 64'(mem_wmask), 64'(v.e_mask));
        chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.e_wdata);
        chk($sformatf("v%0d mem_wen", idx),   64'(mem_wen), 64'(v.we));
        chk($sformatf("v%0d stall", idx),     64'(stall), 64'd1);
        for (int i = 0; i < int'(v.rdy_dly); i++) begin
            tick();
            chk($sformatf("v%0d hold_req", idx),   64'(mem_req), 64'd1);
            chk($sformatf("v%0d hold_mask", idx),  64'(mem_wmask), 64'(v.e_mask));
            chk($sformatf("v%0d hold_wdata", idx), mem_wdata, v.e_wdata);
            chk($sformatf("v%0d hold_addr", idx),  mem_addr, v.e_addr);
        end
        mem_ready = 1'b1;
        mem_rdata = v.rdata;
        mem_rvalid = (!v.we && v.rv_dly == 0);
        tick();
        mem_ready = 1'b0;
        mem_rvalid = 1'b0;
        if (!v.we && v.rv_dly != 0) begin
            chk($sformatf("v%0d req_dropped", idx), 64'(mem_req), 64'd0);
            for (int i = 0; i < int'(v.rv_dly); i++) begin
                chk($sformatf("v%0d wait_noresp", idx), 64'(resp_valid), 64'd0);
                chk($sformatf("v%0d wait_stall", idx),  64'(stall), 64'd1);
                if (i == int'(v.rv_dly) - 1) mem_rvalid = 1'b1;
                tick();
                mem_rvalid = 1'b0;
            end
        end
        chk($sformatf("v%0d resp_valid", idx), 64'(resp_valid), 64'd1);
        chk($sformatf("v%0d resp_rdata", idx), resp_rdata, v.e_rdata);
        chk($sformatf("v%0d resp_err", idx),   64'(resp_err), 64'd0);
        held = v.e_rdata;
        tick();
        chk($sformatf("v%0d resp_pulse", idx), 64'(resp_valid), 64'd0);
        chk($sformatf("v%0d ready_again", idx), 64'(req_ready), 64'd1);
        chk($sformatf("v%0d stall_low", idx),  64'(stall), 64'd0);
        chk($sformatf("v%0d rdata_hold", idx), resp_rdata, held);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_op = MEM_NO;
        req_addr = '0; req_wdata = '0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = '0;
        tick(); tick();
        chk("rst req_ready",  64'(req_ready), 64'd0);
        chk("rst resp_valid", 64'(resp_valid), 64'd0);
        chk("rst resp_err",   64'(resp_err), 64'd0);
        chk("rst resp_rdata", resp_rdata, 64'd0);
        chk("rst mem_req",    64'(mem_req), 64'd0);
        chk("rst mem_wen",    64'(mem_wen), 64'd0);
        chk("rst mem_addr",   mem_addr, 64'd0);
        chk("rst mem_wdata",  mem_wdata, 64'd0);
        chk("rst mem_wmask",  64'(mem_wmask), 64'd0);
        chk("rst stall",      64'(stall), 64'd0);
        rst = 1'b0;
        tick();
        chk("idle req_ready", 64'(req_ready), 64'd1);

        //          we    op      addr        wdata                  rdata                  rdy rv  e_addr      mask   e_wdata                e_rdata
        vecs.push_back(mk(1'b0, MEM_B,  64'h1003, 64'h0,                 64'h00000000_80000000, 0, 0, 64'h1000, 8'h08, 64'h0,                 64'hFFFFFFFF_FFFFFF80));
        vecs.push_back(mk(1'b1, MEM_H,  64'h2002, 64'hBEEF,              64'h0,                 3, 0, 64'h2000, 8'h0C, 64'h00000000_BEEF0000, 64'h0));
        vecs.push_back(mk(1'b0, MEM_UW, 64'h0010, 64'h0,                 64'hFFFFFFFF_80000001, 0, 4, 64'h0010, 8'h0F, 64'h0,                 64'h00000000_80000001));
        vecs.push_back(mk(1'b0, MEM_D,  64'h0028, 64'h0,                 64'h01234567_89ABCDEF, 1, 1, 64'h0028, 8'hFF, 64'h0,                 64'h01234567_89ABCDEF));
        vecs.push_back(mk(1'b0, MEM_H,  64'h0046, 64'h0,                 64'h80010000_00000000, 0, 0, 64'h0040, 8'hC0, 64'h0,                 64'hFFFFFFFF_FFFF8001));
        vecs.push_back(mk(1'b0, MEM_UB, 64'h0007, 64'h0,                 64'hFE000000_00000000, 0, 2, 64'h0000, 8'h80, 64'h0,                 64'h00000000_000000FE));
        vecs.push_back(mk(1'b0, MEM_W,  64'h0004, 64'h0,                 64'h80000000_00000000, 0, 0, 64'h0000, 8'hF0, 64'h0,                 64'hFFFFFFFF_80000000));
        vecs.push_back(mk(1'b1, MEM_D,  64'h0100, 64'hDEADBEEF_CAFEF00D, 64'h0,                 0, 0, 64'h0100, 8'hFF, 64'hDEADBEEF_CAFEF00D, 64'h0));
        vecs.push_back(mk(1'b1, MEM_B,  64'h0035, 64'h12345678_9ABCDEF0, 64'h0,                 2, 0, 64'h0030, 8'h20, 64'hBCDEF000_00000000, 64'h0));
`ifndef MISALIGN_TRAP_EN
        vecs.push_back(mk(1'b0, MEM_W,  64'h3002, 64'h0,                 64'h11223344_55667788, 0, 0, 64'h3000, 8'h3C, 64'h0,                 64'h00000000_33445566));
        vecs.push_back(mk(1'b0, MEM_UH, 64'h0003, 64'h0,                 64'h000000AB_CD000000, 0, 1, 64'h0000, 8'h18, 64'h0,                 64'h00000000_0000ABCD));
`endif

        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

        // Load leaving nonzero data, then MEM_NO must report zero with no bus activity.
        run_vec(100, mk(1'b0, MEM_D, 64'h0, 64'h0, 64'hA5A5A5A5_5A5A5A5A, 0, 0,
                        64'h0, 8'hFF, 64'h0, 64'hA5A5A5A5_5A5A5A5A));
        req_valid = 1'b1; req_we = 1'b0; req_op = MEM_NO; req_addr = 64'h55;
        tick();
        req_valid = 1'b0;
        chk("memno mem_req",    64'(mem_req), 64'd0);
        chk("memno resp_valid", 64'(resp_valid), 64'd1);
        chk("memno resp_rdata", resp_rdata, 64'd0);
        tick();
        chk("memno pulse",      64'(resp_valid), 64'd0);
        chk("memno mem_req2",   64'(mem_req), 64'd0);

        // Stray read return while idle must be ignored and leave resp_rdata alone.
        mem_rvalid = 1'b1; mem_rdata = 64'h1111;
        tick();
        mem_rvalid = 1'b0;
        chk("idle_rvalid resp_valid", 64'(resp_valid), 64'd0);
        chk("idle_rvalid rdata",      resp_rdata, 64'd0);
        chk("idle_rvalid stall",      64'(stall), 64'd0);

        // Reset while waiting for read data aborts the transaction.
        req_valid = 1'b1; req_we = 1'b0; req_op = MEM_D; req_addr = 64'h8;
        tick();
        req_valid = 1'b0;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("abort in_wait stall", 64'(stall), 64'd1);
        rst = 1'b1;
        tick();
        chk("abort mem_req",    64'(mem_req), 64'd0);
        chk("abort resp_valid", 64'(resp_valid), 64'd0);
        chk("abort req_ready",  64'(req_ready), 64'd0);
        chk("abort stall",      64'(stall), 64'd0);
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 64'hFFFF;
        tick();
        chk("abort late_rv resp_valid", 64'(resp_valid), 64'd0);
        chk("abort late_rv req_ready",  64'(req_ready), 64'd1);
        tick();
        mem_rvalid = 1'b0;
        chk("abort late_rv2 resp_valid", 64'(resp_valid), 64'd0);
        chk("abort late_rv rdata",       resp_rdata, 64'd0);

`ifdef MISALIGN_TRAP_EN
        req_valid = 1'b1; req_we = 1'b0; req_op = MEM_W; req_addr = 64'h3002;
        tick();
        req_valid = 1'b0;
        chk("trap mem_req",    64'(mem_req), 64'd0);
        chk("trap resp_valid", 64'(resp_valid), 64'd1);
        chk("trap resp_err",   64'(resp_err), 64'd1);
        chk("trap resp_rdata", resp_rdata, 64'd0);
        tick();
        chk("trap pulse",      64'(resp_valid), 64'd0);
        chk("trap err_clear",  64'(resp_err), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter ADDR_W, default 64, SHALL set the width of the request and memory address ports.
REQ-002 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1, SHALL be the reset: synchronous, active-high.
REQ-004 Port req_valid, input, 1, SHALL mean a pipeline memory operation is presented.
REQ-005 Port req_ready, output, 1, SHALL mean the controller accepts a request this cycle.
REQ-006 Port req_we, input, 1, SHALL select store (1) or load (0).
REQ-007 Port req_op, input, CorePack::mem_op_enum, SHALL give the access size and signedness (MEM_NO/B/H/W/D/UB/UH/UW).
REQ-008 Ports req_addr (input, ADDR_W) and req_wdata (input, CorePack::data_t) SHALL carry the byte address and the unshifted store data.
REQ-009 Ports resp_valid (output, 1) and resp_rdata (output, CorePack::data_t) SHALL carry the completion pulse and the truncated, extended load result.
REQ-010 Port resp_err, output, 1, SHALL flag a misaligned access alongside resp_valid (only with MISALIGN_TRAP_EN).
REQ-011 Ports mem_req, mem_wen (outputs, 1), mem_addr (output, ADDR_W), mem_wdata (output, CorePack::data_t) and mem_wmask (output, 8) SHALL form the memory request channel.
REQ-012 Ports mem_ready (input, 1), mem_rvalid (input, 1) and mem_rdata (input, CorePack::data_t) SHALL be the memory accept strobe and read-return channel.
REQ-013 Port stall, output, 1, SHALL be high whenever state is not IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, REQ, WAIT, DONE.
REQ-015 req_ready SHALL be 1 only in IDLE; a request is accepted on req_valid && req_ready, latching we, op, addr, wdata.
REQ-016 Accepted op != MEM_NO SHALL go IDLE->REQ; op == MEM_NO SHALL go IDLE->DONE with no bus transaction and resp_rdata = 0.
REQ-017 In REQ, mem_req SHALL be 1, holding mem_addr = {addr[ADDR_W-1:3], 3'b000}, mem_wen, mem_wdata and mem_wmask stable until mem_ready.
REQ-018 mem_wdata SHALL equal latched wdata << (addr[2:0]*8); mem_wmask SHALL be 8'h01/8'h03/8'h0F/8'hFF for B/H/W/D (U variants alike), shifted left by addr[2:0], upper bits dropped.
REQ-019 On mem_ready in REQ: store -> DONE; load with mem_rvalid the same cycle -> DONE capturing data; load otherwise -> WAIT.
REQ-020 In WAIT the FSM SHALL hold until mem_rvalid, then capture and go DONE.
REQ-021 Captured load data SHALL be mem_rdata >> (addr[2:0]*8), then the low 8/16/32/64 bits sign-extended (B/H/W) or zero-extended (UB/UH/UW) or passed (D) to 64 bits.
REQ-022 DONE SHALL assert resp_valid for exactly one cycle, then return to IDLE; stores report resp_rdata = 0.
REQ-023 Minimum latency acceptance-to-resp_valid SHALL be 2 cycles for a bus op (ready+rvalid in first REQ cycle) and 1 cycle for MEM_NO.
REQ-024 mem_rvalid outside REQ/WAIT SHALL be ignored.
REQ-025 resp_rdata SHALL hold its value until the next DONE.

Reset
REQ-026 rst SHALL force IDLE at the next edge from any state, aborting any in-flight transaction.
REQ-027 Under reset: req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_req=0, mem_wen=0, mem_addr=0, mem_wdata=0, mem_wmask=0, stall=0.
REQ-028 A mem_rvalid arriving after a reset-abort SHALL not produce resp_valid.

Configuration
REQ-029 Macro MISALIGN_TRAP_EN defined: an accepted H/UH with addr[0]!=0, W/UW with addr[1:0]!=0, or D with addr[2:0]!=0 SHALL go IDLE->DONE, no mem_req, resp_err=1, resp_rdata=0.
REQ-030 Macro undefined: no alignment check; resp_err SHALL be tied 0; misaligned accesses issue with truncated mask per REQ-018.

Verification
REQ-031 Load MEM_B addr 0x1003, mem_rdata 0x00000000_80000000 returned with mem_ready -> mem_addr 0x1000, resp_rdata 0xFFFFFFFF_FFFFFF80 two cycles after acceptance.
REQ-032 Store MEM_H addr 0x2002 wdata 0xBEEF -> mem_wen=1, mem_wmask 8'h0C, mem_wdata 0x00000000_BEEF0000, held while mem_ready=0 for 3 cycles.
REQ-033 Load MEM_UW addr 0x10, mem_ready then mem_rvalid 4 cycles later with rdata 0xFFFF_FFFF_8000_0001 -> stall high throughout, resp_rdata 0x00000000_80000001, one-cycle resp_valid.
REQ-034 req_valid with MEM_NO -> no mem_req, resp_valid next cycle, resp_rdata 0.
REQ-035 rst asserted in WAIT, then mem_rvalid -> IDLE, mem_req=0, no resp_valid.
REQ-036 MISALIGN_TRAP_EN: load MEM_W addr 0x3002 -> no mem_req, resp_valid with resp_err=1; undefined: same access issues mem_wmask 8'h3C.
